// File: rtl/tile_dispatcher_pkg.sv
// Shared types and constants for the tile dispatcher: tile kinds, dispatcher
// states, queue entry layout, and the LFSR parameters.
package tetris;

  localparam int unsigned LfsrWidth = 16;
  localparam logic [LfsrWidth-1:0] LfsrMask = 16'hB400;

  typedef enum logic [2:0] {eNon, eI, eO, eT, eS, eZ, eJ, eL} tile_type_e;

  // Draw index 0..6 selects one of the seven real tiles.
  localparam tile_type_e TileLut [7] = '{eI, eO, eT, eS, eZ, eJ, eL};

  typedef enum logic [1:0] {eFILL, eIDLE, eISSUE, eWAIT} dispatch_state_e;

  typedef struct packed {
    tile_type_e tile_type;
    logic [1:0] angle;
  } tile_entry_t;

endpackage

// File: rtl/tile_dispatcher_if.sv
// Game/executor-facing handshake bundle of the tile dispatcher. Suffixes are
// from the dispatcher's point of view.
interface tile_dispatcher_if;
  import tetris::*;

  logic       spawn_req_i;
  logic       spawn_ready_o;
  logic       v_o;
  logic       done_i;
  tile_type_e tile_type_o;
  logic [1:0] tile_type_angle_o;
  logic       spawned_o;
  tile_type_e preview_type_o;

  modport slave (
    input  spawn_req_i,
    input  done_i,
    output spawn_ready_o,
    output v_o,
    output tile_type_o,
    output tile_type_angle_o,
    output spawned_o,
    output preview_type_o
  );

  modport master (
    output spawn_req_i,
    output done_i,
    input  spawn_ready_o,
    input  v_o,
    input  tile_type_o,
    input  tile_type_angle_o,
    input  spawned_o,
    input  preview_type_o
  );

endinterface

// File: rtl/tile_dispatcher_lfsr.sv
// Free-running 16-bit Galois LFSR (right shift, feedback mask from tetris),
// the random source for tile draws.
module tile_lfsr
  import tetris::*;
#(
  parameter logic [LfsrWidth-1:0] seed_p = 16'hACE1
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  output logic [LfsrWidth-1:0] lfsr_o
);

  logic [LfsrWidth-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q >> 1;
    if (state_q[0]) state_d = state_d ^ LfsrMask;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= seed_p;
    else            state_q <= state_d;
  end

  assign lfsr_o = state_q;

endmodule

// File: rtl/tile_dispatcher.sv
// Tile dispatcher: keeps a preview queue of random tiles topped up from the
// LFSR and hands the head tile to the executor on request.
module tile_dispatcher
  import tetris::*;
#(
  parameter int unsigned queue_depth_p = 4,
  parameter logic [15:0] lfsr_seed_p   = 16'hACE1
) (
  input logic              clk_i,
  input logic              reset_n_i,
  tile_dispatcher_if.slave bus
);

  localparam int unsigned PtrW = (queue_depth_p > 1) ? $clog2(queue_depth_p) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(queue_depth_p);

  // Random draw
  logic [LfsrWidth-1:0] lfsr;
  logic [2:0]           draw_idx;
  logic                 draw_valid;
  tile_entry_t          draw_entry;
  logic                 unused_lfsr;

  tile_lfsr #(
    .seed_p(lfsr_seed_p)
  ) u_lfsr (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .lfsr_o   (lfsr)
  );

  assign draw_idx    = lfsr[2:0];
  assign draw_valid  = (draw_idx != 3'd7);
  assign unused_lfsr = ^lfsr[LfsrWidth-1:5];

  always_comb begin
    draw_entry.tile_type = eNon;
    draw_entry.angle     = lfsr[4:3];
    if (draw_valid) draw_entry.tile_type = TileLut[draw_idx];
  end

  // Preview queue
  tile_entry_t     queue_q [queue_depth_p];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            q_full, q_empty, push, pop;
  tile_entry_t     head;

  dispatch_state_e state_q, state_d;
  logic            spawn_ready, load, accept, wait_exit;
  logic            wait_first_q, spawned_q;
  tile_entry_t     issue_q;

  assign q_full  = (count_q == FullCnt);
  assign q_empty = (count_q == '0);
  assign push    = draw_valid && !q_full;
  assign pop     = accept && !q_empty;
  assign head    = queue_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Storage needs no reset: entries are only read below count_q.
  always_ff @(posedge clk_i) begin
    if (push) queue_q[wr_ptr_q] <= draw_entry;
  end

  // Dispatch FSM
  assign load      = spawn_ready && bus.spawn_req_i;
  assign accept    = (state_q == eISSUE) && bus.done_i;
  // The first eWAIT cycle ignores done_i: it may still reflect the accept.
  assign wait_exit = (state_q == eWAIT) && !wait_first_q && bus.done_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= eFILL;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      eFILL:   if (count_d == FullCnt) state_d = eIDLE;
      eIDLE:   if (load)               state_d = eISSUE;
      eISSUE:  if (accept)             state_d = eWAIT;
      eWAIT:   if (wait_exit)          state_d = eIDLE;
      default:                         state_d = eFILL;
    endcase
  end

  always_comb begin
    spawn_ready = (state_q == eIDLE) && !q_empty;
    bus.v_o     = (state_q == eISSUE);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wait_first_q <= 1'b0;
      spawned_q    <= 1'b0;
      issue_q      <= '{tile_type: eNon, angle: 2'd0};
    end else begin
      wait_first_q <= accept;
      spawned_q    <= wait_exit;
      if (load) issue_q <= head;
    end
  end

  assign bus.spawn_ready_o     = spawn_ready;
  assign bus.spawned_o         = spawned_q;
  assign bus.tile_type_o       = issue_q.tile_type;
  assign bus.tile_type_angle_o = issue_q.angle;
  assign bus.preview_type_o    = q_empty ? eNon : head.tile_type;

endmodule

// File: tb/tb_tile_dispatcher.sv
// Bench for tile_dispatcher: two instances (default seed and a seed whose first
// draw is index 7) checked every cycle against a behavioural model.
module tb_tile_dispatcher;
  import tetris::*;

  localparam int          Depth  = 4;
  localparam logic [15:0] Seed0  = 16'hACE1;
  localparam logic [15:0] Seed1  = 16'hACE7;
  localparam int          SFill  = 0;
  localparam int          SIdle  = 1;
  localparam int          SIssue = 2;
  localparam int          SWait  = 3;

  typedef struct packed {
    tile_type_e t;
    logic [1:0] a;
  } ent_t;

  logic clk_i   = 1'b0;
  logic reset_n = 1'b0;
  logic req     = 1'b0;
  logic done    = 1'b1;

  always #5 clk_i = ~clk_i;

  tile_dispatcher_if bus0 ();
  tile_dispatcher_if bus1 ();

  assign bus0.spawn_req_i = req;
  assign bus0.done_i      = done;
  assign bus1.spawn_req_i = req;
  assign bus1.done_i      = done;

  tile_dispatcher #(
    .queue_depth_p(Depth),
    .lfsr_seed_p  (Seed0)
  ) dut0 (
    .clk_i    (clk_i),
    .reset_n_i(reset_n),
    .bus      (bus0)
  );

  tile_dispatcher #(
    .queue_depth_p(Depth),
    .lfsr_seed_p  (Seed1)
  ) dut1 (
    .clk_i    (clk_i),
    .reset_n_i(reset_n),
    .bus      (bus1)
  );

  // Reference model state; m_q holds expected preview entries, sb holds
  // the tile each honoured request must present at accept.
  logic [15:0] m_lfsr    [2];
  int          m_st      [2];
  bit          m_first   [2];
  bit          m_spawned [2];
  ent_t        m_tile    [2];
  ent_t        m_q       [2][$];
  ent_t        sb        [2][$];

  int n_checks = 0;
  int n_pass   = 0;
  int n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset(input int k);
    m_lfsr[k]    = (k == 0) ? Seed0 : Seed1;
    m_st[k]      = SFill;
    m_first[k]   = 1'b0;
    m_spawned[k] = 1'b0;
    m_tile[k]    = '{t: eNon, a: 2'd0};
    m_q[k].delete();
    sb[k].delete();
  endtask

  task automatic observe(input int k, output logic rdy, output logic v, output logic sp,
                         output tile_type_e tt, output logic [1:0] ang, output tile_type_e pv);
    if (k == 0) begin
      rdy = bus0.spawn_ready_o; v = bus0.v_o; sp = bus0.spawned_o;
      tt = bus0.tile_type_o; ang = bus0.tile_type_angle_o; pv = bus0.preview_type_o;
    end else begin
      rdy = bus1.spawn_ready_o; v = bus1.v_o; sp = bus1.spawned_o;
      tt = bus1.tile_type_o; ang = bus1.tile_type_angle_o; pv = bus1.preview_type_o;
    end
  endtask

  task automatic check_all(input int k);
    logic rdy, v, sp;
    logic [1:0] ang;
    tile_type_e tt, pv, exp_pv;
    bit exp_rdy;
    observe(k, rdy, v, sp, tt, ang, pv);
    exp_rdy = (m_st[k] == SIdle) && (m_q[k].size() != 0);
    exp_pv  = (m_q[k].size() != 0) ? m_q[k][0].t : eNon;
    check($sformatf("ready%0d", k),   32'(rdy), 32'(exp_rdy));
    check($sformatf("v%0d", k),       32'(v),   32'(m_st[k] == SIssue));
    check($sformatf("spawned%0d", k), 32'(sp),  32'(m_spawned[k]));
    check($sformatf("tile%0d", k),    32'(tt),  32'(m_tile[k].t));
    check($sformatf("angle%0d", k),   32'(ang), 32'(m_tile[k].a));
    check($sformatf("preview%0d", k), 32'(pv),  32'(exp_pv));
  endtask

  task automatic model_step(input int k);
    logic [2:0] idx;
    bit valid, push, accept, load, rdy;
    ent_t d, exp_e;
    int st_n;
    logic orr, ov, osp;
    logic [1:0] oang;
    tile_type_e ott, opv;
    idx    = m_lfsr[k][2:0];
    valid  = (idx != 3'd7);
    d.t    = tile_type_e'(idx + 3'd1);
    d.a    = m_lfsr[k][4:3];
    push   = valid && (m_q[k].size() < Depth);
    rdy    = (m_st[k] == SIdle) && (m_q[k].size() != 0);
    accept = (m_st[k] == SIssue) && done;
    load   = rdy && req;
    st_n   = m_st[k];
    case (m_st[k])
      SIdle:   if (load) st_n = SIssue;
      SIssue:  if (accept) st_n = SWait;
      SWait:   if (!m_first[k] && done) st_n = SIdle;
      default: st_n = m_st[k];
    endcase
    m_spawned[k] = (m_st[k] == SWait) && !m_first[k] && done;
    m_first[k]   = accept;
    if (load) begin
      m_tile[k] = m_q[k][0];
      sb[k].push_back(m_q[k][0]);
    end
    if (accept) begin
      observe(k, orr, ov, osp, ott, oang, opv);
      check($sformatf("sb_depth%0d", k), 32'(sb[k].size()), 32'd1);
      if (sb[k].size() != 0) begin
        exp_e = sb[k].pop_front();
        check($sformatf("accept_tile%0d", k),  32'(ott),  32'(exp_e.t));
        check($sformatf("accept_angle%0d", k), 32'(oang), 32'(exp_e.a));
      end
      void'(m_q[k].pop_front());
    end
    if (push) m_q[k].push_back(d);
    if (m_st[k] == SFill && m_q[k].size() == Depth) st_n = SIdle;
    m_st[k]   = st_n;
    m_lfsr[k] = m_lfsr[k][0] ? ((m_lfsr[k] >> 1) ^ 16'hB400) : (m_lfsr[k] >> 1);
  endtask

  task automatic cycle();
    for (int k = 0; k < 2; k++) check_all(k);
    if (reset_n) for (int k = 0; k < 2; k++) model_step(k);
    @(negedge clk_i);
  endtask

  task automatic wait_ready0();
    int cnt = 0;
    while (bus0.spawn_ready_o !== 1'b1 && cnt < 50) begin
      cycle();
      cnt++;
    end
    check("ready_timeout", 32'(bus0.spawn_ready_o), 32'd1);
  endtask

  // Release reset and count ready-low cycles of dut0, pulsing req early on.
  task automatic release_and_fill(input string tag);
    reset_n = 1'b1;
    done    = 1'b1;
    n = 0;
    while (bus0.spawn_ready_o !== 1'b1 && n < 20) begin
      req = (n < 2);
      cycle();
      n++;
    end
    req = 1'b0;
    check(tag, 32'(n), 32'd4);
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
    @(negedge clk_i);
    repeat (2) cycle();

    release_and_fill("fill_len");

    // Single spawn, executor busy two cycles after accept.
    req = 1'b1; cycle();
    req = 1'b0; cycle();
    done = 1'b0; req = 1'b1; cycle(); cycle();
    done = 1'b1; req = 1'b0;
    n = 3;
    while (bus0.spawned_o !== 1'b1 && n < 12) begin
      cycle();
      n++;
    end
    check("spawn_lat", 32'(n), 32'd4);
    repeat (3) cycle();

    // Executor stalls issue for 10 cycles.
    wait_ready0();
    req = 1'b1; cycle();
    req = 1'b0; done = 1'b0;
    repeat (10) cycle();
    check("v_hold", 32'(bus0.v_o), 32'd1);
    done = 1'b1;
    repeat (4) cycle();

    // Reset while v_o is high.
    wait_ready0();
    req = 1'b1; cycle();
    req = 1'b0; done = 1'b0; cycle(); cycle();
    check("v_pre_reset", 32'(bus0.v_o), 32'd1);
    reset_n = 1'b0;
    #1;
    check("v_async", 32'(bus0.v_o), 32'd0);
    model_reset(0);
    model_reset(1);
    @(negedge clk_i);
    repeat (2) cycle();
    release_and_fill("fill_len2");

    // Reset mid-eWAIT.
    req = 1'b1; cycle();
    req = 1'b0; cycle();
    done = 1'b0; cycle();
    reset_n = 1'b0;
    #1;
    check("v_wait_reset", 32'(bus0.v_o), 32'd0);
    check("spawned_wait_reset", 32'(bus0.spawned_o), 32'd0);
    model_reset(0);
    model_reset(1);
    @(negedge clk_i);
    done = 1'b1;
    repeat (3) cycle();
    release_and_fill("fill_len3");

    // Random traffic.
    repeat (300) begin
      req  = 1'($urandom_range(0, 1));
      done = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tile_dispatcher.md
TILE_DISPATCHER -- requirements
Module: tile_dispatcher

Interface
REQ-001 SHALL have parameter queue_depth_p, default 4, preview-queue depth (power of two, 2..8).
REQ-002 SHALL have parameter lfsr_seed_p, default 16'hACE1, LFSR reset value (zero illegal).
REQ-003 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset_n_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port spawn_req_i  input  1  game request for the next tile, honoured only while spawn_ready_o=1.
REQ-006 SHALL have port spawn_ready_o  output  1  dispatcher idle and queue non-empty.
REQ-007 SHALL have port v_o  output  1  spawn valid toward the executor.
REQ-008 SHALL have port done_i  input  1  executor idle/done; a spawn is accepted in any cycle where v_o=1 and done_i=1.
REQ-009 SHALL have port tile_type_o  output  tile_type_e  tile type being spawned.
REQ-010 SHALL have port tile_type_angle_o  output  2  initial angle being spawned.
REQ-011 SHALL have port spawned_o  output  1  one-cycle pulse when the executor finishes a spawn.
REQ-012 SHALL have port preview_type_o  output  tile_type_e  queue-head type; eNon when queue empty.

Function
REQ-013 SHALL contain a 16-bit Galois LFSR, mask 16'hB400, advancing every cycle.
REQ-014 SHALL form a draw each cycle: index = lfsr[2:0], angle = lfsr[4:3]; draw valid only when index != 7.
REQ-015 SHALL map index 0..6 through the package tile-lookup constant to the seven non-eNon tile_type_e values.
REQ-016 SHALL push the valid draw {type, angle} into the queue whenever the queue is not full; index 7 draws are discarded, no push.
REQ-017 SHALL pop the queue head on the spawn-accept cycle; a push and a pop in the same cycle both take effect, count unchanged.
REQ-018 SHALL never overflow (no push when full) nor underflow (no pop when empty).
REQ-019 SHALL implement FSM states eFILL, eIDLE, eISSUE, eWAIT.
REQ-020 eFILL SHALL transition to eIDLE on the cycle the queue becomes full; spawn_ready_o=0 throughout eFILL.
REQ-021 spawn_ready_o SHALL equal (state==eIDLE and queue non-empty).
REQ-022 On spawn_req_i=1 while spawn_ready_o=1, SHALL register the queue head into tile_type_o/tile_type_angle_o and enter eISSUE on the next edge.
REQ-023 spawn_req_i SHALL be ignored in all other states or cycles; no request is queued.
REQ-024 In eISSUE, v_o SHALL be 1, with tile_type_o/tile_type_angle_o held stable until accept.
REQ-025 On accept (eISSUE and done_i=1), SHALL pop the queue and enter eWAIT; v_o SHALL fall on the next cycle.
REQ-026 If done_i=0 in eISSUE, SHALL remain in eISSUE with v_o held high indefinitely.
REQ-027 The first eWAIT cycle SHALL ignore done_i; eWAIT SHALL exit to eIDLE at the first later cycle with done_i=1.
REQ-028 spawned_o SHALL pulse for exactly one cycle, registered, in the cycle after the eWAIT exit.
REQ-029 tile_type_o/tile_type_angle_o SHALL retain the last spawned values until the next request.
REQ-030 Queue refill SHALL continue in every state.

Reset
REQ-031 On reset_n_i=0, SHALL asynchronously set: state eFILL, queue empty, lfsr=lfsr_seed_p, v_o=0, spawned_o=0, tile_type_o=eNon, tile_type_angle_o=0.
REQ-032 Reset asserted mid-eISSUE/eWAIT SHALL abandon the spawn without a spawned_o pulse; v_o=0 immediately.

Structure
REQ-033 Package tetris SHALL hold the tile-lookup constant (7 entries), the LFSR mask/width constants, and dispatch_state_e.
REQ-034 The LFSR SHALL be a sub-module tile_lfsr (seed parameter, 16-bit state out); the queue stays inline.

Verification
REQ-035 Reset release, default params -> spawn_ready_o=0 for at least 4 cycles, then 1; preview_type_o sequence matches a golden LFSR model.
REQ-036 done_i tied 1, pulse spawn_req_i -> v_o=1 for exactly 1 cycle; tile_type_o = prior preview; executor model drops done_i for 2 cycles -> spawned_o one pulse 3 cycles after accept.
REQ-037 done_i held 0 for 10 cycles in eISSUE -> v_o high and tile_type_o stable all 10 cycles; accept on cycle 11.
REQ-038 spawn_req_i pulsed during eWAIT and during eFILL -> ignored, no v_o, queue count unchanged.
REQ-039 Seed chosen so lfsr[2:0]=7 -> no push that cycle; preview sequence skips it; queue never exceeds 4 entries.
REQ-040 reset_n_i asserted mid-eWAIT -> v_o=0, no spawned_o; after release, behaviour identical to REQ-035.
